// File: rtl/esfa_cmd_issuer.sv
// esfa_cmd_issuer: drives one ESFA command word at a time and returns the captured response.
// Optional statistics counters are enabled with the ESFA_ISSUER_STATS_EN macro.
module esfa_cmd_issuer #(
  parameter int RESP_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_index,
  input  logic [7:0]  cmd_value,
  input  logic [7:0]  cmd_metadata,
  input  logic        cmd_is_meta,
  input  logic [7:0]  cmd_selector,
  output logic [47:0] bus_out,
  input  logic [47:0] bus_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_bool,
  output logic [7:0]  rsp_value,
  output logic        rsp_err
`ifdef ESFA_ISSUER_STATS_EN
  ,
  output logic [15:0] stat_cmds,
  output logic [15:0] stat_errs
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Counter value in the last ISSUE/WAIT cycle before the response is sampled.
  localparam logic [3:0] LAST_CNT = 4'(RESP_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [47:0] bus_out_q, bus_out_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_bool_q, rsp_bool_d;
  logic [7:0]  rsp_value_q, rsp_value_d;
  logic        rsp_err_q, rsp_err_d;
  logic        accept;
  logic        capture;
  logic [3:0]  cnt_inc;
  logic [47:0] packed_word;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  assign packed_word = {cmd_selector, 7'b0, cmd_is_meta, cmd_metadata,
                        cmd_value, cmd_index, 7'b0, cmd_write};

  always_comb begin
    state_d     = state_q;
    bus_out_d   = bus_out_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_bool_d  = rsp_bool_q;
    rsp_value_d = rsp_value_q;
    rsp_err_d   = rsp_err_q;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus_out_d = 48'h0;
        if (accept) begin
          state_d   = S_ISSUE;
          bus_out_d = packed_word;
          cnt_d     = 4'd0;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          capture     = 1'b1;
          state_d     = S_RESP;
          bus_out_d   = 48'h0;
          rsp_valid_d = 1'b1;
          rsp_bool_d  = bus_in[7:0];
          rsp_value_d = bus_in[15:8];
          rsp_err_d   = |bus_in[47:16];
        end else begin
          // Keep the fields on the bus but drop the write bit: one-cycle strobe.
          state_d   = S_WAIT;
          bus_out_d = {bus_out_q[47:1], 1'b0};
          cnt_d     = cnt_inc;
        end
      end
      S_RESP: begin
        bus_out_d = 48'h0;
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bus_out_d = 48'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bus_out_q   <= 48'h0;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_bool_q  <= 8'h0;
      rsp_value_q <= 8'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_out_q   <= bus_out_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bool_q  <= rsp_bool_d;
      rsp_value_q <= rsp_value_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus_out   = bus_out_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_bool  = rsp_bool_q;
  assign rsp_value = rsp_value_q;
  assign rsp_err   = rsp_err_q;

`ifdef ESFA_ISSUER_STATS_EN
  logic [15:0] stat_cmds_q, stat_cmds_d;
  logic [15:0] stat_errs_q, stat_errs_d;

  always_comb begin
    stat_cmds_d = stat_cmds_q;
    stat_errs_d = stat_errs_q;
    if (accept) stat_cmds_d = stat_cmds_q + 16'd1;
    if (capture && (|bus_in[47:16])) stat_errs_d = stat_errs_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cmds_q <= 16'h0;
      stat_errs_q <= 16'h0;
    end else begin
      stat_cmds_q <= stat_cmds_d;
      stat_errs_q <= stat_errs_d;
    end
  end

  assign stat_cmds = stat_cmds_q;
  assign stat_errs = stat_errs_q;
`endif

endmodule
